// File: rtl/led_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// led_mode_ctrl : short/long push-button classifier driving a 4-mode LED
//                 sequencer (OFF / ON / SLOW blink / FAST blink).
// Revision 1.0
// ============================================================================
module led_mode_ctrl #(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] LONG_CNT  = CNT_W'(25000000),
    parameter logic [CNT_W-1:0] SLOW_HALF = CNT_W'(12500000),
    parameter logic [CNT_W-1:0] FAST_HALF = CNT_W'(2500000)
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       btn_i,
    output logic       led_o,
    output logic [1:0] mode_o,
    output logic       short_evt_o,
    output logic       long_evt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } press_state_t;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_ON   = 2'd1;
    localparam logic [1:0] MODE_SLOW = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = LONG_CNT  - CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOW_LAST = SLOW_HALF - CNT_W'(1);
    localparam logic [CNT_W-1:0] FAST_LAST = FAST_HALF - CNT_W'(1);

    press_state_t     state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
    logic [CNT_W-1:0] half_last;
    logic [1:0]       mode, mode_nxt;
    logic             btn_d;
    logic             blink_q, blink_q_nxt;
    logic             press_start;
    logic             short_nxt, long_nxt;
    logic             led_nxt;
    logic             mode_chg;

    // btn_d resets low so a button held through reset never looks like a new press
    assign press_start = btn_d & ~btn_i;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            btn_d       <= 1'b0;
            short_evt_o <= 1'b0;
            long_evt_o  <= 1'b0;
            mode        <= MODE_OFF;
            blink_cnt   <= '0;
            blink_q     <= 1'b0;
            led_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            btn_d       <= btn_i;
            short_evt_o <= short_nxt;
            long_evt_o  <= long_nxt;
            mode        <= mode_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_q     <= blink_q_nxt;
            led_o       <= led_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_start) begin
                    state_nxt = ST_PRESSED;
                    hold_nxt  = CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (btn_i) begin
                    state_nxt = ST_IDLE;
                    short_nxt = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_HELD;
                    long_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // the long event already fired; release just re-arms
                if (btn_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Mode and blink phase move on the same edge that raises the event pulse
    assign mode_chg  = short_nxt | long_nxt;
    assign half_last = (mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

    always_comb begin
        mode_nxt = mode;
        if (long_nxt) begin
            mode_nxt = MODE_OFF;
        end else if (short_nxt) begin
            mode_nxt = mode + 2'd1;
        end
    end

    always_comb begin
        blink_cnt_nxt = blink_cnt;
        blink_q_nxt   = blink_q;
        if (mode_chg) begin
            blink_cnt_nxt = '0;
            blink_q_nxt   = 1'b1;
        end else if (mode[1]) begin
            if (blink_cnt == half_last) begin
                blink_cnt_nxt = '0;
                blink_q_nxt   = ~blink_q;
            end else begin
                blink_cnt_nxt = blink_cnt + CNT_W'(1);
            end
        end else begin
            blink_cnt_nxt = '0;
        end
    end

    always_comb begin
        led_nxt = blink_q;
        case (mode)
            MODE_OFF: led_nxt = 1'b0;
            MODE_ON:  led_nxt = 1'b1;
            default:  led_nxt = blink_q;
        endcase
    end

    assign mode_o = mode;

    a_one_event: assert property (@(posedge sysclk) disable iff (!rst_n)
        !(short_evt_o && long_evt_o));
    a_hold_bound: assert property (@(posedge sysclk) disable iff (!rst_n)
        hold_cnt <= HOLD_LAST);

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_led_mode_ctrl : vector table, directed corner sequences and random press
//                    traffic checked against a run-length reference model.
// Revision 1.0
// ============================================================================
module tb_led_mode_ctrl;

    localparam int LONG = 8;
    localparam int SLOW = 6;
    localparam int FAST = 2;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       btn_i  = 1'b1;
    logic       led_o;
    logic [1:0] mode_o;
    logic       short_evt_o;
    logic       long_evt_o;

    led_mode_ctrl #(
        .CNT_W     (32),
        .LONG_CNT  (32'd8),
        .SLOW_HALF (32'd6),
        .FAST_HALF (32'd2)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .led_o       (led_o),
        .mode_o      (mode_o),
        .short_evt_o (short_evt_o),
        .long_evt_o  (long_evt_o)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks presses as low-sample run lengths and the LED
    // level as a function of time elapsed since the last mode change.
    int cyc, entry, run, m_mode;
    bit prev_btn, pressing, long_done;
    bit e_short, e_long, e_led;

    function automatic bit led_level(int md, int since);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((since / SLOW) % 2) == 0;
            default: return ((since / FAST) % 2) == 0;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0; entry = 0; run = 0; m_mode = 0;
        prev_btn = 1'b0; pressing = 1'b0; long_done = 1'b0;
        e_short = 1'b0; e_long = 1'b0; e_led = 1'b0;
    endtask

    task automatic model_edge(input bit b);
        bit old_led;
        old_led = led_level(m_mode, cyc - entry);
        cyc++;
        e_short = 1'b0;
        e_long  = 1'b0;
        if (pressing) begin
            if (b) begin
                e_short  = !long_done;
                pressing = 1'b0;
            end else if (!long_done) begin
                run++;
                if (run == LONG) begin
                    e_long    = 1'b1;
                    long_done = 1'b1;
                end
            end
        end else if (prev_btn && !b) begin
            pressing  = 1'b1;
            run       = 1;
            long_done = 1'b0;
        end
        if (e_short) begin m_mode = (m_mode + 1) % 4; entry = cyc; end
        if (e_long)  begin m_mode = 0;                entry = cyc; end
        e_led    = old_led;
        prev_btn = b;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("short_evt", short_evt_o, e_short);
        chk("long_evt",  long_evt_o,  e_long);
        chk("mode",      mode_o,      m_mode);
        chk("led",       led_o,       e_led);
    endtask

    task automatic step(input bit b);
        btn_i = b;
        @(posedge sysclk);
        #1;
        model_edge(b);
        chk_model();
    endtask

    task automatic press(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
        step(1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_led",   led_o,       0);
        chk("rst_mode",  mode_o,      0);
        chk("rst_short", short_evt_o, 0);
        chk("rst_long",  long_evt_o,  0);
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit       btn;
        bit       s;
        bit       l;
        bit [1:0] md;
        bit       led;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1};

        // Power-on reset
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        chk("por_led",   led_o,       0);
        chk("por_mode",  mode_o,      0);
        chk("por_short", short_evt_o, 0);
        chk("por_long",  long_evt_o,  0);
        rst_n = 1'b1;

        // 3-sample short press from the vector table
        foreach (tbl[i]) begin
            step(tbl[i].btn);
            chk("tbl_short", short_evt_o, tbl[i].s);
            chk("tbl_long",  long_evt_o,  tbl[i].l);
            chk("tbl_mode",  mode_o,      tbl[i].md);
            chk("tbl_led",   led_o,       tbl[i].led);
        end

        // Walk ON->SLOW->FAST->OFF, dwelling long enough to see blinking
        press(3);
        chk("to_slow", mode_o, 2);
        repeat (20) step(1'b1);
        press(2);
        chk("to_fast", mode_o, 3);
        repeat (10) step(1'b1);
        press(1);
        chk("to_off", mode_o, 0);
        repeat (3) step(1'b1);

        // 20-sample long press: pulse right after the 8th low sample
        for (int i = 1; i <= 20; i++) begin
            step(1'b0);
            chk("long_at", long_evt_o, (i == LONG) ? 1 : 0);
        end
        step(1'b1);
        chk("no_short_after_long", short_evt_o, 0);
        repeat (2) step(1'b1);

        // Button held through reset, then released, then a real press
        btn_i = 1'b0;
        apply_reset();
        repeat (3) step(1'b0);
        chk("held_thru_rst", short_evt_o, 0);
        step(1'b1);
        chk("held_release", short_evt_o, 0);
        press(3);
        chk("after_rst_mode", mode_o, 1);
        step(1'b1);

        // Reset while PRESSED at hold count 5, button stays low afterwards
        repeat (5) step(1'b0);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            chk("rst_mid_evt", short_evt_o | long_evt_o, 0);
        end
        step(1'b1);
        chk("rst_mid_release", short_evt_o, 0);

        // Long press while blinking in SLOW
        press(2);
        press(2);
        chk("slow_again", mode_o, 2);
        repeat (4) step(1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (i == LONG)     chk("long_in_slow_mode", mode_o, 0);
            if (i == LONG + 1) begin
                chk("long_in_slow_led", led_o, 0);
                chk("long_in_slow_blink_cnt", dut.blink_cnt, 0);
            end
        end
        step(1'b1);

        // Random press traffic with occasional asynchronous reset
        for (int seg = 0; seg < 400; seg++) begin
            bit lvl;
            int len;
            lvl = seg[0];
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 9);
            for (int k = 0; k < len; k++) step(lvl);
            if ($urandom_range(0, 60) == 0) apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
